sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameter MEM_AW, default 8: storage array address width; MEM_AW>=5; depth 2**MEM_AW x 16.
REQ-002 Parameter MAX_CL, default 3: deepest supported CAS latency; legal CAS latencies are 2 and 3.
REQ-003 clk  in  1  single clock; all state is sampled on the posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 clock_enable  in  1  CKE; when 0, the command is ignored and treated as a NOP.
REQ-006 cs_n, ras_n, cas_n, we_n  in  1 each  command strobes.
REQ-007 addr  in  13  row address (ACT), column + A10 (READ/WRITE), A10 all-banks (PRE), mode value (MRS).
REQ-008 bank_addr  in  2  bank select.
REQ-009 data_in  in  16  write data from the controller.
REQ-010 data_oe  in  1  controller is driving data_in.
REQ-011 data_out  out  16  read data to the controller.
REQ-012 data_valid  out  1  data_out holds read data this cycle.
REQ-013 ready  out  1  init sequence complete.
REQ-014 err  out  1  sticky protocol-violation flag.

Function
REQ-015 Decode when CKE=1 and cs_n=0, using {ras_n,cas_n,we_n}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS.
REQ-016 Decode cs_n=1 as deselect, treated as NOP.
REQ-017 Init FSM states: S_UNINIT -> (PRE with A10=1) S_PRE -> (REF) S_REF1 -> (REF) S_REF2 -> (MRS) S_READY.
REQ-018 In the init FSM, other non-NOP commands hold the current state; S_READY persists until reset.
REQ-019 ready=1 iff the init FSM is in S_READY.
REQ-020 MRS latches addr[6:4] as CL; a value other than 2 or 3 sets err, and CL then defaults to 3.
REQ-021 addr[2:0] is ignored; burst length is always 1.
REQ-022 Each of the 4 banks keeps an active bit and a 13-bit open-row register.
REQ-023 ACT sets the active bit and latches addr into the open-row register.
REQ-024 PRE with A10=1 clears all active bits; PRE with A10=0 clears only the active bit of bank_addr.
REQ-025 Storage index = {bank_addr, open_row[bank][1:0], addr[MEM_AW-5:0]}.
REQ-026 WRITE stores data_in at the index on the command edge; 0-cycle write latency.
REQ-027 READ sampled at edge N loads data_out at edge N+CL-1 and asserts data_valid for exactly one cycle.
REQ-028 READ latency uses a MAX_CL-deep shift pipeline; back-to-back READs each return data in order, one per cycle.
REQ-029 READ or WRITE with addr[10]=1 (auto-precharge) clears that bank's active bit after the access, in the same edge.
REQ-030 REF changes no bank or memory state.
REQ-031 data_out holds its last value when data_valid=0.
REQ-032 An MRS arriving during an in-flight READ does not alter that READ's latency; CL is captured per READ.

Reset
REQ-033 rst_n=0 immediately forces: data_out=16'h0000, data_valid=0, ready=0, err=0, init FSM=S_UNINIT, all bank active bits=0, read pipeline flushed, CL=3.
REQ-034 Storage array contents are not reset.
REQ-035 A reset asserted mid-READ drops the pending data; no data_valid pulse follows deassertion.

Configuration
REQ-036 Macro SDRAM_RESP_ERR_CHECK_EN defined: err is set sticky on any of:
  - ACT to an active bank;
  - READ or WRITE to an idle bank;
  - ACT, READ or WRITE while ready=0;
  - WRITE with data_oe=0;
  - data_oe=1 on a non-WRITE cycle;
  - REF while any bank is active;
  - illegal CL (REQ-020).
REQ-037 Macro SDRAM_RESP_ERR_CHECK_EN undefined: err is tied 0, no check logic is built, and illegal CL silently selects 3.

Verification
REQ-038 Init: reset, PRE(A10=1), NOP x2, REF, NOP x8, REF, NOP x8, MRS addr=13'h0030 -> ready=1 on the edge after MRS, CL=3, err=0.
REQ-039 Write/read: ACT bank 2 row 13'h0001; WRITE col 5, A10=1, data_oe=1, data_in=16'hBEEF; ACT bank 2 row 1; READ col 5 at edge N -> data_out=16'hBEEF and data_valid=1 exactly at edge N+2 only.
REQ-040 Back-to-back: three READs on consecutive cycles to cols 0,1,2 holding 16'h1111/16'h2222/16'h3333 -> three consecutive data_valid cycles in that order.
REQ-041 Violation (macro on): READ to idle bank 1 -> err=1 next edge and stays 1 through subsequent legal traffic; same stimulus with macro off -> err=0.
REQ-042 Reset mid-read: READ at edge N, rst_n low between N and N+1 -> data_valid never asserts, data_out=16'h0000, ready=0.
REQ-043 CL=2: MRS addr=13'h0020, then READ at edge N -> data_valid at N+1; CKE=0 on a READ cycle -> no data_valid and no state change.

Source files
------------

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device model: command decode, init tracking, per-bank row state, CL-delayed reads.
// Optional protocol checking is built only when SDRAM_RESP_ERR_CHECK_EN is defined.
module sdram_responder #(
   parameter int MEM_AW = 8,
   parameter int MAX_CL = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clock_enable,
   input  logic        cs_n,
   input  logic        ras_n,
   input  logic        cas_n,
   input  logic        we_n,
   input  logic [12:0] addr,
   input  logic [1:0]  bank_addr,
   input  logic [15:0] data_in,
   input  logic        data_oe,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic        ready,
   output logic        err
);

   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_MRS = 3'b000;
   localparam int NSLOT = MAX_CL - 1;

   typedef enum logic [2:0] {S_UNINIT, S_PRE, S_REF1, S_REF2, S_READY} state_t;
   typedef struct packed {
      logic        vld;
      logic [15:0] dat;
   } slot_t;

   logic [2:0] cmd;
   logic       cmd_en;
   logic       is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;

   assign cmd    = {ras_n, cas_n, we_n};
   assign cmd_en = clock_enable & ~cs_n;
   assign is_act = cmd_en && (cmd == CMD_ACT);
   assign is_rd  = cmd_en && (cmd == CMD_RD);
   assign is_wr  = cmd_en && (cmd == CMD_WR);
   assign is_pre = cmd_en && (cmd == CMD_PRE);
   assign is_ref = cmd_en && (cmd == CMD_REF);
   assign is_mrs = cmd_en && (cmd == CMD_MRS);

   state_t state, state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_UNINIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_UNINIT: if (is_pre && addr[10]) state_nxt = S_PRE;
         S_PRE:    if (is_ref) state_nxt = S_REF1;
         S_REF1:   if (is_ref) state_nxt = S_REF2;
         S_REF2:   if (is_mrs) state_nxt = S_READY;
         default:  state_nxt = state;
      endcase
   end

   assign ready = (state == S_READY);

   logic [2:0] mrs_cl;
   logic       cl_legal;
   logic [1:0] cl_q;

   assign mrs_cl   = addr[6:4];
   assign cl_legal = (mrs_cl == 3'd2) || (mrs_cl == 3'd3);

   // Bank state and CAS latency register
   logic [3:0]  bank_act;
   logic [12:0] open_row [4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cl_q     <= 2'd3;
         bank_act <= '0;
         for (int b = 0; b < 4; b++) open_row[b] <= '0;
      end else begin
         if (is_mrs) cl_q <= cl_legal ? mrs_cl[1:0] : 2'd3;
         if (is_act) begin
            bank_act[bank_addr] <= 1'b1;
            open_row[bank_addr] <= addr;
         end
         if (is_pre) begin
            if (addr[10]) bank_act <= '0;
            else          bank_act[bank_addr] <= 1'b0;
         end
         if ((is_rd || is_wr) && addr[10]) bank_act[bank_addr] <= 1'b0;
      end
   end

   logic [15:0]       mem [2**MEM_AW];
   logic [MEM_AW-1:0] mem_idx;
   logic [12:0]       cur_row;

   assign cur_row = open_row[bank_addr];
   assign mem_idx = {bank_addr, cur_row[1:0], addr[MEM_AW-5:0]};

   always_ff @(posedge clk) begin
      if (is_wr) mem[mem_idx] <= data_in;
   end

   // Each READ enters the slot that matches its own CL, so later MRS cannot retime it
   slot_t pipe [NSLOT];
   slot_t pipe_nxt [NSLOT];
   int    rd_slot;

   assign rd_slot = int'(cl_q) - 2;

   always_comb begin
      for (int i = 0; i < NSLOT - 1; i++) pipe_nxt[i] = pipe[i+1];
      pipe_nxt[NSLOT-1] = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (is_rd && (i == rd_slot)) pipe_nxt[i] = {1'b1, mem[mem_idx]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSLOT; i++) pipe[i] <= '0;
         data_out   <= 16'h0000;
         data_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NSLOT; i++) pipe[i] <= pipe_nxt[i];
         data_valid <= pipe[0].vld;
         if (pipe[0].vld) data_out <= pipe[0].dat;
      end
   end

`ifdef SDRAM_RESP_ERR_CHECK_EN
   logic viol;
   logic err_q;

   always_comb begin
      viol = 1'b0;
      if (is_act && (bank_act[bank_addr] || !ready)) viol = 1'b1;
      if ((is_rd || is_wr) && (!bank_act[bank_addr] || !ready)) viol = 1'b1;
      if (is_wr && !data_oe) viol = 1'b1;
      if (data_oe && !is_wr) viol = 1'b1;
      if (is_ref && (|bank_act)) viol = 1'b1;
      if (is_mrs && !cl_legal) viol = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_q | viol;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   logic unused_sink;
   assign unused_sink = ^{data_oe, open_row[0], open_row[1], open_row[2], open_row[3], cur_row};

endmodule

// File: tb/tb_sdram_responder.sv
// Directed, table-driven bench for sdram_responder with hand-written reset and error sequences.
module tb_sdram_responder;

   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] RD  = 4'b0101;
   localparam logic [3:0] WR  = 4'b0100;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] REF = 4'b0001;
   localparam logic [3:0] MRS = 4'b0000;
   localparam logic [3:0] DES = 4'b1101;

`ifdef SDRAM_RESP_ERR_CHECK_EN
   localparam logic E = 1'b1;
`else
   localparam logic E = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clock_enable;
   logic        cs_n, ras_n, cas_n, we_n;
   logic [12:0] addr;
   logic [1:0]  bank_addr;
   logic [15:0] data_in;
   logic        data_oe;
   logic [15:0] data_out;
   logic        data_valid;
   logic        ready;
   logic        err;

   always #5 clk = ~clk;

   sdram_responder #(.MEM_AW(8), .MAX_CL(3)) dut (
      .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable),
      .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
      .addr(addr), .bank_addr(bank_addr), .data_in(data_in), .data_oe(data_oe),
      .data_out(data_out), .data_valid(data_valid), .ready(ready), .err(err)
   );

   typedef struct {
      logic        cke;
      logic [3:0]  c;
      logic [1:0]  ba;
      logic [12:0] a;
      logic [15:0] din;
      logic        oe;
      logic        vld;
      logic [15:0] dout;
      logic        rdy;
   } vec_t;

   vec_t tbl[$];
   int   init_len;
   int   checks = 0;
   int   fails  = 0;

   function automatic vec_t mk(input logic cke, input logic [3:0] c, input logic [1:0] ba,
                               input logic [12:0] a, input logic [15:0] din, input logic oe,
                               input logic vld, input logic [15:0] dout, input logic rdy);
      vec_t v;
      v.cke = cke; v.c = c; v.ba = ba; v.a = a; v.din = din; v.oe = oe;
      v.vld = vld; v.dout = dout; v.rdy = rdy;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s step=%0d got=%h expected=%h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic cke, input logic [3:0] c, input logic [1:0] ba,
                        input logic [12:0] a, input logic [15:0] din, input logic oe);
      clock_enable = cke;
      {cs_n, ras_n, cas_n, we_n} = c;
      bank_addr = ba; addr = a; data_in = din; data_oe = oe;
   endtask

   task automatic step(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] din, input logic oe);
      drive(1'b1, c, ba, a, din, oe);
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      drive(v.cke, v.c, v.ba, v.a, v.din, v.oe);
      @(posedge clk);
      #1;
      chk("data_valid", idx, {15'b0, data_valid}, {15'b0, v.vld});
      chk("data_out",   idx, data_out, v.dout);
      chk("ready",      idx, {15'b0, ready}, {15'b0, v.rdy});
      chk("err",        idx, {15'b0, err}, 16'h0000);
   endtask

   initial begin
      // init sequence, with an early MRS that must not advance the FSM
      tbl.push_back(mk(1, PRE, 0, 13'h400, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, REF, 0, 0, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, MRS, 0, 13'h030, 0, 0, 0, 16'h0000, 0));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, REF, 0, 0, 0, 0, 0, 16'h0000, 0));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h0000, 0));
      tbl.push_back(mk(1, MRS, 0, 13'h030, 0, 0, 0, 16'h0000, 1));
      init_len = tbl.size();
      // write with auto-precharge, re-open, read at CL3
      tbl.push_back(mk(1, ACT, 2, 13'h001, 0, 0, 0, 16'h0000, 1));
      tbl.push_back(mk(1, WR,  2, 13'h405, 16'hBEEF, 1, 0, 16'h0000, 1));
      tbl.push_back(mk(1, ACT, 2, 13'h001, 0, 0, 0, 16'h0000, 1));
      tbl.push_back(mk(1, RD,  2, 13'h005, 0, 0, 0, 16'h0000, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h0000, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 1, 16'hBEEF, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'hBEEF, 1));
      // back-to-back reads
      tbl.push_back(mk(1, WR,  2, 13'h000, 16'h1111, 1, 0, 16'hBEEF, 1));
      tbl.push_back(mk(1, WR,  2, 13'h001, 16'h2222, 1, 0, 16'hBEEF, 1));
      tbl.push_back(mk(1, WR,  2, 13'h002, 16'h3333, 1, 0, 16'hBEEF, 1));
      tbl.push_back(mk(1, RD,  2, 13'h000, 0, 0, 0, 16'hBEEF, 1));
      tbl.push_back(mk(1, RD,  2, 13'h001, 0, 0, 0, 16'hBEEF, 1));
      tbl.push_back(mk(1, RD,  2, 13'h002, 0, 0, 1, 16'h1111, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 1, 16'h2222, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 1, 16'h3333, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h3333, 1));
      // open-row bits take part in the storage index
      tbl.push_back(mk(1, PRE, 2, 13'h000, 0, 0, 0, 16'h3333, 1));
      tbl.push_back(mk(1, ACT, 2, 13'h002, 0, 0, 0, 16'h3333, 1));
      tbl.push_back(mk(1, WR,  2, 13'h000, 16'h4444, 1, 0, 16'h3333, 1));
      tbl.push_back(mk(1, PRE, 2, 13'h000, 0, 0, 0, 16'h3333, 1));
      tbl.push_back(mk(1, ACT, 2, 13'h001, 0, 0, 0, 16'h3333, 1));
      tbl.push_back(mk(1, RD,  2, 13'h000, 0, 0, 0, 16'h3333, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h3333, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 1, 16'h1111, 1));
      // CL=2, CKE low and deselect
      tbl.push_back(mk(1, MRS, 0, 13'h020, 0, 0, 0, 16'h1111, 1));
      tbl.push_back(mk(1, RD,  2, 13'h001, 0, 0, 0, 16'h1111, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 1, 16'h2222, 1));
      tbl.push_back(mk(0, RD,  2, 13'h002, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, DES, 2, 13'h002, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(0, WR,  2, 13'h001, 16'hDEAD, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, RD,  2, 13'h000, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, RD,  2, 13'h001, 0, 0, 1, 16'h1111, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 1, 16'h2222, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h2222, 1));
      // CL is captured per READ: MRS while a CL3 read is in flight
      tbl.push_back(mk(1, MRS, 0, 13'h030, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, RD,  2, 13'h000, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, MRS, 0, 13'h020, 0, 0, 0, 16'h2222, 1));
      tbl.push_back(mk(1, RD,  2, 13'h002, 0, 0, 1, 16'h1111, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 1, 16'h3333, 1));
      tbl.push_back(mk(1, NOP, 0, 0, 0, 0, 0, 16'h3333, 1));

      rst_n = 1'b0;
      drive(1'b1, NOP, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data_out",   -1, data_out, 16'h0000);
      chk("rst_data_valid", -1, {15'b0, data_valid}, 16'h0000);
      chk("rst_ready",      -1, {15'b0, ready}, 16'h0000);
      chk("rst_err",        -1, {15'b0, err}, 16'h0000);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      // READ to idle bank 1; error must stick through legal traffic
      step(RD, 1, 13'h000, 0, 0);
      chk("viol_err", 100, {15'b0, err}, {15'b0, E});
      step(NOP, 0, 0, 0, 0);
      chk("viol_err", 101, {15'b0, err}, {15'b0, E});
      step(ACT, 0, 13'h001, 0, 0);
      chk("viol_err", 102, {15'b0, err}, {15'b0, E});
      step(WR, 0, 13'h003, 16'h5A5A, 1);
      chk("viol_err", 103, {15'b0, err}, {15'b0, E});
      step(RD, 0, 13'h003, 0, 0);
      chk("viol_err", 104, {15'b0, err}, {15'b0, E});
      step(NOP, 0, 0, 0, 0);
      chk("viol_err", 105, {15'b0, err}, {15'b0, E});
      chk("viol_vld", 105, {15'b0, data_valid}, 16'h0001);
      chk("viol_dat", 105, data_out, 16'h5A5A);

      // reset between a READ edge and its data edge
      step(RD, 2, 13'h001, 0, 0);
      drive(1'b1, NOP, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_data_out", 200, data_out, 16'h0000);
      chk("midrst_valid",    200, {15'b0, data_valid}, 16'h0000);
      chk("midrst_ready",    200, {15'b0, ready}, 16'h0000);
      chk("midrst_err",      200, {15'b0, err}, 16'h0000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(NOP, 0, 0, 0, 0);
         chk("postrst_valid", 201 + i, {15'b0, data_valid}, 16'h0000);
         chk("postrst_data",  201 + i, data_out, 16'h0000);
         chk("postrst_ready", 201 + i, {15'b0, ready}, 16'h0000);
      end

      // re-init, then an illegal CL falls back to 3; storage survives reset
      for (int i = 0; i < init_len; i++) run_vec(tbl[i], 300 + i);
      step(MRS, 0, 13'h020, 0, 0);
      chk("cl_err", 400, {15'b0, err}, 16'h0000);
      step(MRS, 0, 13'h070, 0, 0);
      chk("cl_err", 401, {15'b0, err}, {15'b0, E});
      chk("cl_ready", 401, {15'b0, ready}, 16'h0001);
      step(ACT, 2, 13'h001, 0, 0);
      step(RD, 2, 13'h001, 0, 0);
      chk("cl3_vld", 402, {15'b0, data_valid}, 16'h0000);
      step(NOP, 0, 0, 0, 0);
      chk("cl3_vld", 403, {15'b0, data_valid}, 16'h0000);
      step(NOP, 0, 0, 0, 0);
      chk("cl3_vld", 404, {15'b0, data_valid}, 16'h0001);
      chk("cl3_dat", 404, data_out, 16'h2222);
      step(NOP, 0, 0, 0, 0);
      chk("cl3_vld", 405, {15'b0, data_valid}, 16'h0000);
      chk("cl_err",  405, {15'b0, err}, {15'b0, E});

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
